fifo_d_reader: RTL and testbench
================================

FIFO_D_READER -- requirements
Module: fifo_d_reader

Interface
REQ-001 Parameter data_width, default 6, word width of both destination FIFOs and of the merged output.
REQ-002 Parameter count_width, default 8, width of each per-destination word counter.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 enable  input  1  when 1, the block may start new reads; when 0, no new pops are issued.
REQ-006 data_in_D0  input  data_width  read data from the D0 FIFO, valid the cycle after D0_pop.
REQ-007 data_in_D1  input  data_width  read data from the D1 FIFO, valid the cycle after D1_pop.
REQ-008 empty_D0, empty_D1  input  1 each  FIFO empty flags.
REQ-009 out_ready  input  1  the downstream sink accepts data_out this cycle.
REQ-010 D0_pop, D1_pop  output  1 each  single-cycle read strobes to the FIFOs.
REQ-011 data_out  output  data_width  merged output word.
REQ-012 valid_out  output  1  data_out and dest_out hold a valid word.
REQ-013 dest_out  output  1  source of the current word: 0 = D0, 1 = D1.
REQ-014 count_D0, count_D1  output  count_width each  words delivered from each FIFO.
REQ-015 busy  output  1  1 whenever state is not IDLE.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, READ and HOLD.
REQ-017 IDLE: if enable=1 and at least one empty flag is 0, the FSM SHALL select a source, assert that source's pop for that cycle only, and go to READ; otherwise it stays in IDLE.
REQ-018 Selection rule: if only one FIFO is non-empty, select it; if both are non-empty, select the source not served last (round-robin).
REQ-019 READ: the FSM SHALL register the selected data_in into data_out, drive dest_out to the selected source, set valid_out=1 and go to HOLD; no pop is asserted in READ.
REQ-020 HOLD: while out_ready=0, data_out, dest_out and valid_out SHALL remain stable.
REQ-021 HOLD with out_ready=1: the word is consumed; the count for dest_out SHALL increment by 1 and the last-served pointer SHALL update to dest_out.
REQ-022 On that consuming cycle, valid_out SHALL drop, and the FSM SHALL apply the IDLE selection rule directly (pop plus go to READ, or go to IDLE), using the updated last-served pointer.
REQ-023 Minimum spacing between words is therefore 2 cycles (pop, capture/present); data_out appears 2 cycles after the pop edge.
REQ-024 At most one pop SHALL be asserted in any cycle, and never to a FIFO whose empty flag is 1 in that cycle.
REQ-025 The block SHALL issue no new pop while a word is outstanding (READ, or HOLD before it is consumed).
REQ-026 enable deasserted in READ or HOLD SHALL NOT abort the transaction: the word is still delivered, after which the FSM goes to IDLE.
REQ-027 The counters SHALL wrap modulo 2^count_width; 255+1 = 0 at the default width.
REQ-028 The empty flags are sampled only when a pop decision is made; flag changes in READ or HOLD SHALL have no effect.

Reset
REQ-029 With reset=1 at a clock edge, state SHALL become IDLE, and valid_out, D0_pop, D1_pop, busy and dest_out SHALL become 0.
REQ-030 On reset, data_out SHALL become 0, both counters SHALL become 0, and the last-served pointer SHALL become D1, so D0 wins the first tie.
REQ-031 Reset asserted mid-transaction SHALL drop the outstanding word without counting it, and no pop is issued in the reset cycle.

Verification
REQ-032 Reset, then D0 non-empty holding 0x05 with out_ready=1 -> D0_pop high 1 cycle, then valid_out=1, data_out=0x05, dest_out=0 two edges later, and count_D0=1.
REQ-033 Both FIFOs non-empty holding 4 words each, out_ready=1 -> dest_out sequence 0,1,0,1,0,1,0,1, a word every 2 cycles, and count_D0=count_D1=4.
REQ-034 out_ready held 0 for 5 cycles while in HOLD with 0x36 -> data_out stays 0x36, no pops occur, and the counters are unchanged until out_ready=1.
REQ-035 enable=0 with both FIFOs non-empty -> no pops and busy=0; enable dropped during READ -> that word is delivered, then the FSM returns to IDLE.
REQ-036 D0 FIFO supplies 256 words -> count_D0 wraps to 0, and there is never a pop while empty_D0=1.
REQ-037 Reset asserted during HOLD -> next cycle valid_out=0, counters=0, and the next tie is served from D0.

Source files
------------

// File: rtl/fifo_d_reader.sv
// fifo_d_reader: round-robin reader for two destination FIFOs (D0, D1).
// Pops one word at a time, captures it the following cycle and presents it
// with a valid/ready handshake. Per-source delivered-word counters wrap.
module fifo_d_reader #(
    parameter int unsigned data_width  = 6,
    parameter int unsigned count_width = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [data_width-1:0]  data_in_D0,
    input  logic [data_width-1:0]  data_in_D1,
    input  logic                   empty_D0,
    input  logic                   empty_D1,
    input  logic                   out_ready,
    output logic                   D0_pop,
    output logic                   D1_pop,
    output logic [data_width-1:0]  data_out,
    output logic                   valid_out,
    output logic                   dest_out,
    output logic [count_width-1:0] count_D0,
    output logic [count_width-1:0] count_D1,
    output logic                   busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [data_width-1:0]  data_q, data_d;
    logic                   dest_q, dest_d;
    logic                   valid_q, valid_d;
    logic [count_width-1:0] cnt_d0_q, cnt_d0_d;
    logic [count_width-1:0] cnt_d1_q, cnt_d1_d;
    logic                   last_q, last_d;   // last served source, 1 = D1
    logic                   sel_q, sel_d;     // source popped, awaiting capture

    logic                   pop0_c, pop1_c;
    logic                   try_c;            // a pop decision is taken this cycle
    logic                   ptr_c;            // last-served value used for the decision
    logic                   pick_c;

    // Next-state, datapath and pop-strobe decode
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        dest_d   = dest_q;
        valid_d  = valid_q;
        cnt_d0_d = cnt_d0_q;
        cnt_d1_d = cnt_d1_q;
        last_d   = last_q;
        sel_d    = sel_q;
        pop0_c   = 1'b0;
        pop1_c   = 1'b0;
        try_c    = 1'b0;
        ptr_c    = last_q;
        pick_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                try_c = 1'b1;
            end
            ST_READ: begin
                data_d  = sel_q ? data_in_D1 : data_in_D0;
                dest_d  = sel_q;
                valid_d = 1'b1;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    if (dest_q) begin
                        cnt_d1_d = cnt_d1_q + count_width'(1);
                    end else begin
                        cnt_d0_d = cnt_d0_q + count_width'(1);
                    end
                    last_d  = dest_q;
                    ptr_c   = dest_q;
                    try_c   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Shared selection: sole non-empty source, else the one not served last
        if (try_c && enable && !(empty_D0 && empty_D1)) begin
            pick_c  = (!empty_D0 && !empty_D1) ? ~ptr_c : empty_D0;
            sel_d   = pick_c;
            state_d = ST_READ;
            pop0_c  = ~pick_c;
            pop1_c  = pick_c;
        end

        // A reset cycle never pops: the FIFO would lose a word nobody captures
        if (reset) begin
            pop0_c = 1'b0;
            pop1_c = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            data_q   <= '0;
            dest_q   <= 1'b0;
            valid_q  <= 1'b0;
            cnt_d0_q <= '0;
            cnt_d1_q <= '0;
            last_q   <= 1'b1;
            sel_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            dest_q   <= dest_d;
            valid_q  <= valid_d;
            cnt_d0_q <= cnt_d0_d;
            cnt_d1_q <= cnt_d1_d;
            last_q   <= last_d;
            sel_q    <= sel_d;
        end
    end

    assign D0_pop    = pop0_c;
    assign D1_pop    = pop1_c;
    assign data_out  = data_q;
    assign dest_out  = dest_q;
    assign valid_out = valid_q;
    assign count_D0  = cnt_d0_q;
    assign count_D1  = cnt_d1_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fifo_d_reader.sv
// Testbench for fifo_d_reader: FIFO environment built from queues plus a
// word-level reference model (in-flight word / presented word / counters).
module tb_fifo_d_reader;

    localparam int unsigned DW = 6;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          reset, enable, out_ready;
    logic [DW-1:0] data_in_D0, data_in_D1;
    logic          empty_D0, empty_D1;
    logic          D0_pop, D1_pop;
    logic [DW-1:0] data_out;
    logic          valid_out, dest_out, busy;
    logic [CW-1:0] count_D0, count_D1;

    always #5 clk = ~clk;

    fifo_d_reader #(.data_width(DW), .count_width(CW)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .data_in_D0(data_in_D0), .data_in_D1(data_in_D1),
        .empty_D0(empty_D0), .empty_D1(empty_D1), .out_ready(out_ready),
        .D0_pop(D0_pop), .D1_pop(D1_pop), .data_out(data_out),
        .valid_out(valid_out), .dest_out(dest_out),
        .count_D0(count_D0), .count_D1(count_D1), .busy(busy)
    );

    int asserts = 0;
    int fails   = 0;

    // FIFO environment
    logic [DW-1:0] q0[$], q1[$];
    logic          have0 = 1'b0, have1 = 1'b0;
    logic [DW-1:0] nxt0 = '0, nxt1 = '0;

    // Reference model
    logic          m_in_flight = 1'b0, m_src = 1'b0;
    logic [DW-1:0] m_word = '0, m_next = '0;
    logic          m_pres = 1'b0, m_dest = 1'b0, m_last = 1'b1;
    logic [DW-1:0] m_data = '0;
    logic [CW-1:0] m_cnt0 = '0, m_cnt1 = '0;
    logic          m_consume, m_can, m_sel, e_pop0, e_pop1;

    // Apply inputs for this cycle and work out what the model expects to pop
    task automatic drive();
        logic ne0, ne1, ptr;
        empty_D0   = (q0.size() == 0);
        empty_D1   = (q1.size() == 0);
        data_in_D0 = have0 ? nxt0 : DW'($urandom);
        data_in_D1 = have1 ? nxt1 : DW'($urandom);
        ne0 = !empty_D0;
        ne1 = !empty_D1;
        m_consume = m_pres && out_ready && !reset;
        ptr   = m_consume ? m_dest : m_last;
        m_can = !reset && enable && !m_in_flight && (!m_pres || out_ready) && (ne0 || ne1);
        m_sel = (ne0 && ne1) ? !ptr : !ne0;
        e_pop0 = m_can && !m_sel;
        e_pop1 = m_can && m_sel;
        m_next = '0;
        if (m_sel && ne1) m_next = q1[0];
        if (!m_sel && ne0) m_next = q0[0];
        #1;
    endtask

    // Let the FIFOs react to the DUT's pops, update the model, go to next cycle
    task automatic advance();
        have0 = (D0_pop === 1'b1) && (q0.size() > 0);
        have1 = (D1_pop === 1'b1) && (q1.size() > 0);
        if (have0) nxt0 = q0.pop_front();
        if (have1) nxt1 = q1.pop_front();
        if (reset) begin
            m_in_flight = 1'b0; m_pres = 1'b0; m_cnt0 = '0; m_cnt1 = '0;
            m_last = 1'b1; m_data = '0; m_dest = 1'b0;
        end else begin
            if (m_consume) begin
                if (m_dest) m_cnt1 = m_cnt1 + CW'(1);
                else        m_cnt0 = m_cnt0 + CW'(1);
                m_last = m_dest;
                m_pres = 1'b0;
            end
            if (m_in_flight) begin
                m_pres = 1'b1; m_data = m_word; m_dest = m_src;
            end
            m_in_flight = m_can; m_src = m_sel; m_word = m_next;
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; out_ready = 1'b0;
        drive(); advance();
        reset = 1'b0;
        q0.delete(); q1.delete();
    endtask

    task automatic test_reset();
        q0.delete(); q1.delete();
        q0.push_back(6'h01); q1.push_back(6'h02);
        reset = 1'b1; enable = 1'b1; out_ready = 1'b1;
        drive();
        asserts++;
        if ({D0_pop, D1_pop} !== 2'b00) begin fails++; $display("FAIL reset_pop got=%b exp=00", {D0_pop, D1_pop}); end
        advance();
        asserts++;
        if (valid_out !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
        asserts++;
        if (data_out !== 6'h00) begin fails++; $display("FAIL reset_data got=%h exp=00", data_out); end
        asserts++;
        if (dest_out !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL reset_dest_busy got=%b%b exp=00", dest_out, busy); end
        asserts++;
        if (count_D0 !== 8'd0 || count_D1 !== 8'd0) begin fails++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", count_D0, count_D1); end
        reset = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        q0.push_back(6'h05); enable = 1'b1; out_ready = 1'b1;
        drive();
        asserts++;
        if ({D0_pop, D1_pop} !== 2'b10) begin fails++; $display("FAIL single_pop got=%b exp=10", {D0_pop, D1_pop}); end
        advance(); drive();
        asserts++;
        if ({D0_pop, D1_pop, valid_out} !== 3'b000) begin fails++; $display("FAIL single_read got=%b exp=000", {D0_pop, D1_pop, valid_out}); end
        advance(); drive();
        asserts++;
        if ({valid_out, dest_out, data_out} !== {1'b1, 1'b0, 6'h05}) begin
            fails++; $display("FAIL single_word got=v%b d%b %h exp=v1 d0 05", valid_out, dest_out, data_out);
        end
        advance(); drive();
        asserts++;
        if (count_D0 !== 8'd1 || valid_out !== 1'b0) begin fails++; $display("FAIL single_count got=%0d v%b exp=1 v0", count_D0, valid_out); end
        advance();
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] e0[$], e1[$];
        logic [DW-1:0] w, exp_w;
        int n = 0, last_i = -1;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            w = DW'($urandom); q0.push_back(w); e0.push_back(w);
            w = DW'($urandom); q1.push_back(w); e1.push_back(w);
        end
        enable = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            drive();
            asserts++;
            if ({D0_pop, D1_pop} !== {e_pop0, e_pop1}) begin fails++; $display("FAIL rr_pop cyc=%0d got=%b exp=%b", i, {D0_pop, D1_pop}, {e_pop0, e_pop1}); end
            if (valid_out === 1'b1) begin
                exp_w = (n % 2 == 0) ? e0.pop_front() : e1.pop_front();
                asserts++;
                if (dest_out !== 1'(n % 2) || data_out !== exp_w) begin
                    fails++; $display("FAIL rr_word n=%0d got=d%b %h exp=d%0d %h", n, dest_out, data_out, n % 2, exp_w);
                end
                if (n > 0) begin
                    asserts++;
                    if (i - last_i != 2) begin fails++; $display("FAIL rr_spacing n=%0d got=%0d exp=2", n, i - last_i); end
                end
                last_i = i; n++;
            end
            advance();
        end
        asserts++;
        if (n != 8 || count_D0 !== 8'd4 || count_D1 !== 8'd4) begin
            fails++; $display("FAIL rr_totals got=%0d words %0d/%0d exp=8 words 4/4", n, count_D0, count_D1);
        end
    endtask

    task automatic test_hold();
        bit found = 0;
        do_reset();
        q0.push_back(6'h36); q1.push_back(6'h11); q1.push_back(6'h12);
        enable = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            drive();
            if (valid_out === 1'b1) found = 1;
            else advance();
        end
        asserts++;
        if (!found) begin fails++; $display("FAIL hold_valid got=0 exp=1 within 10 cycles"); end
        advance();
        for (int k = 0; k < 5; k++) begin
            out_ready = (k == 4);
            drive();
            asserts++;
            if (valid_out !== 1'b1 || data_out !== 6'h36 || count_D0 !== 8'd0 || count_D1 !== 8'd0) begin
                fails++; $display("FAIL hold_stable k=%0d got=v%b %h %0d/%0d exp=v1 36 0/0", k, valid_out, data_out, count_D0, count_D1);
            end
            asserts++;
            if ({D0_pop, D1_pop} !== ((k == 4) ? 2'b01 : 2'b00)) begin
                fails++; $display("FAIL hold_pop k=%0d got=%b exp=%b", k, {D0_pop, D1_pop}, (k == 4) ? 2'b01 : 2'b00);
            end
            advance();
        end
        drive();
        asserts++;
        if (count_D0 !== 8'd1 || valid_out !== 1'b0) begin fails++; $display("FAIL hold_release got=%0d v%b exp=1 v0", count_D0, valid_out); end
        advance();
    endtask

    task automatic test_enable();
        do_reset();
        for (int k = 0; k < 3; k++) begin q0.push_back(DW'(8 + k)); q1.push_back(DW'(16 + k)); end
        enable = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive();
            asserts++;
            if ({D0_pop, D1_pop, busy, valid_out} !== 4'b0000) begin
                fails++; $display("FAIL en_off k=%0d got=%b exp=0000", k, {D0_pop, D1_pop, busy, valid_out});
            end
            advance();
        end
        enable = 1'b1; drive();
        asserts++;
        if ({D0_pop, D1_pop} !== 2'b10) begin fails++; $display("FAIL en_pop got=%b exp=10", {D0_pop, D1_pop}); end
        advance();
        enable = 1'b0; drive();
        asserts++;
        if ({D0_pop, D1_pop, busy} !== 3'b001) begin fails++; $display("FAIL en_read got=%b exp=001", {D0_pop, D1_pop, busy}); end
        advance(); drive();
        asserts++;
        if (valid_out !== 1'b1 || data_out !== 6'd8 || {D0_pop, D1_pop} !== 2'b00) begin
            fails++; $display("FAIL en_deliver got=v%b %h p%b exp=v1 08 p00", valid_out, data_out, {D0_pop, D1_pop});
        end
        advance();
        for (int k = 0; k < 3; k++) begin
            drive();
            asserts++;
            if ({D0_pop, D1_pop, busy, valid_out} !== 4'b0000 || count_D0 !== 8'd1) begin
                fails++; $display("FAIL en_idle k=%0d got=%b c%0d exp=0000 c1", k, {D0_pop, D1_pop, busy, valid_out}, count_D0);
            end
            advance();
        end
    endtask

    task automatic test_wrap();
        int delivered = 0;
        do_reset();
        for (int k = 0; k < 256; k++) q0.push_back(DW'($urandom));
        enable = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 530; i++) begin
            drive();
            asserts++;
            if ({D0_pop, D1_pop} !== {e_pop0, e_pop1} || (D0_pop === 1'b1 && empty_D0 === 1'b1)) begin
                fails++; $display("FAIL wrap_pop cyc=%0d got=%b exp=%b empty=%b", i, {D0_pop, D1_pop}, {e_pop0, e_pop1}, empty_D0);
            end
            asserts++;
            if (count_D0 !== CW'(delivered)) begin fails++; $display("FAIL wrap_count cyc=%0d got=%0d exp=%0d", i, count_D0, CW'(delivered)); end
            if (valid_out === 1'b1) delivered++;
            advance();
        end
        asserts++;
        if (delivered != 256 || count_D0 !== 8'd0) begin fails++; $display("FAIL wrap_total got=%0d c%0d exp=256 c0", delivered, count_D0); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        q0.push_back(6'h21); q0.push_back(6'h22); q1.push_back(6'h31); q1.push_back(6'h32);
        enable = 1'b1; out_ready = 1'b1;
        drive(); advance();             // pop D0
        drive(); advance();             // capture
        drive(); advance();             // deliver D0, pop D1
        out_ready = 1'b0;
        drive(); advance();             // capture
        drive();
        asserts++;
        if (valid_out !== 1'b1 || dest_out !== 1'b1 || count_D0 !== 8'd1) begin
            fails++; $display("FAIL rmid_hold got=v%b d%b c%0d exp=v1 d1 c1", valid_out, dest_out, count_D0);
        end
        advance();
        reset = 1'b1; drive();
        asserts++;
        if ({D0_pop, D1_pop} !== 2'b00) begin fails++; $display("FAIL rmid_pop got=%b exp=00", {D0_pop, D1_pop}); end
        advance();
        reset = 1'b0; out_ready = 1'b1; drive();
        asserts++;
        if (valid_out !== 1'b0 || count_D0 !== 8'd0 || count_D1 !== 8'd0) begin
            fails++; $display("FAIL rmid_clear got=v%b %0d/%0d exp=v0 0/0", valid_out, count_D0, count_D1);
        end
        asserts++;
        if ({D0_pop, D1_pop} !== 2'b10) begin fails++; $display("FAIL rmid_tie got=%b exp=10", {D0_pop, D1_pop}); end
        advance();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (q0.size() < 6 && $urandom_range(2) == 0) q0.push_back(DW'($urandom));
            if (q1.size() < 6 && $urandom_range(2) == 0) q1.push_back(DW'($urandom));
            enable    = ($urandom_range(7) != 0);
            out_ready = ($urandom_range(2) != 0);
            reset     = ($urandom_range(63) == 0);
            drive();
            asserts++;
            if ({D0_pop, D1_pop} !== {e_pop0, e_pop1}) begin fails++; $display("FAIL rnd_pop cyc=%0d got=%b exp=%b", i, {D0_pop, D1_pop}, {e_pop0, e_pop1}); end
            asserts++;
            if (valid_out !== m_pres || busy !== (m_pres || m_in_flight)) begin
                fails++; $display("FAIL rnd_status cyc=%0d got=v%b b%b exp=v%b b%b", i, valid_out, busy, m_pres, m_pres || m_in_flight);
            end
            asserts++;
            if (count_D0 !== m_cnt0 || count_D1 !== m_cnt1) begin
                fails++; $display("FAIL rnd_count cyc=%0d got=%0d/%0d exp=%0d/%0d", i, count_D0, count_D1, m_cnt0, m_cnt1);
            end
            if (m_pres) begin
                asserts++;
                if (data_out !== m_data || dest_out !== m_dest) begin
                    fails++; $display("FAIL rnd_word cyc=%0d got=%h d%b exp=%h d%b", i, data_out, dest_out, m_data, m_dest);
                end
            end
            advance();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; out_ready = 1'b0;
        empty_D0 = 1'b1; empty_D1 = 1'b1; data_in_D0 = '0; data_in_D1 = '0;
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_round_robin();
        test_hold();
        test_enable();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
